// File: rtl/sd_cmd_pkg.sv
// Shared types and constants for the SPI-mode SD command sequencer.
package sd_cmd_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSendLd,
    StSendWt,
    StPollLd,
    StPollWt,
    StTrailLd,
    StTrailWt,
    StFinish
  } sd_cmd_state_e;

  // Command indices issued by the SD mode controller
  localparam logic [5:0] CMD0   = 6'd0;
  localparam logic [5:0] CMD8   = 6'd8;
  localparam logic [5:0] CMD17  = 6'd17;
  localparam logic [5:0] CMD24  = 6'd24;
  localparam logic [5:0] CMD55  = 6'd55;
  localparam logic [5:0] ACMD41 = 6'd41;

  localparam int unsigned FRAME_BYTES = 6;
  localparam int unsigned FRAME_BITS  = FRAME_BYTES * 8;
  localparam logic [1:0]  START_BITS  = 2'b01;

  // Precomputed {crc7, stop} bytes; the only commands that need a valid CRC in SPI mode
  localparam logic [7:0] CRC_CMD0 = 8'h95;
  localparam logic [7:0] CRC_CMD8 = 8'h87;

endpackage

// File: rtl/sd_crc7.sv
// Combinational CRC7 (x^7 + x^3 + 1, init 0) over the 40 leading bits of an SD command frame.
// Only built when SD_CMD_CRC7_EN is defined.
`ifdef SD_CMD_CRC7_EN
module sd_crc7 (
  input  logic [39:0] data_i,
  output logic [6:0]  crc_o
);

  logic [6:0] crc;
  logic       fb;

  // Bit-serial LFSR unrolled over the frame head, MSB first
  always_comb begin
    crc = '0;
    fb  = 1'b0;
    for (int i = 39; i >= 0; i--) begin
      fb  = data_i[i] ^ crc[6];
      crc = {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
  end

  assign crc_o = crc;

endmodule
`endif

// File: rtl/sd_cmd_sequencer.sv
// SPI-mode SD command sequencer: frames a 6-byte command, polls for R1 within an NCR window,
// clocks one trailer byte, then releases chip select. Optional CRC7 generator: SD_CMD_CRC7_EN.
module sd_cmd_sequencer
  import sd_cmd_pkg::*;
#(
  parameter int unsigned NCR_MAX   = 8,
  parameter logic [7:0]  FILL_BYTE = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  output logic        cmd_busy,
  output logic        cmd_done,
  output logic        cmd_timeout,
  output logic [7:0]  resp_r1,
  output logic [7:0]  spi_tx_byte,
  output logic        spi_tx_load,
  input  logic        spi_byte_done,
  input  logic [7:0]  spi_rx_byte,
  output logic        sd_cs_n
);

  localparam int unsigned PollW = $clog2(NCR_MAX) + 1;

  sd_cmd_state_e         state_q, state_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic [2:0]            byte_cnt_q, byte_cnt_d;
  logic [PollW-1:0]      poll_cnt_q, poll_cnt_d;
  logic                  flag_q, flag_d;
  logic [7:0]            resp_q, resp_d;
  logic [7:0]            tx_byte_q, tx_byte_d;
  logic                  tx_load_q, tx_load_d;
  logic                  cs_n_q, cs_n_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  timeout_q, timeout_d;
  logic [7:0]            crc_byte;

`ifdef SD_CMD_CRC7_EN
  logic [6:0] crc7;

  sd_crc7 u_crc7 (
    .data_i ({START_BITS, cmd_index, cmd_arg}),
    .crc_o  (crc7)
  );

  assign crc_byte = {crc7, 1'b1};
`else
  // Fixed CRC bytes for the commands that are CRC-checked in SPI mode; others send all ones
  always_comb begin
    crc_byte = 8'hFF;
    case (cmd_index)
      CMD0:    crc_byte = CRC_CMD0;
      CMD8:    crc_byte = CRC_CMD8;
      default: crc_byte = 8'hFF;
    endcase
  end
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    byte_cnt_d = byte_cnt_q;
    poll_cnt_d = poll_cnt_q;
    flag_d     = flag_q;
    resp_d     = resp_q;
    tx_byte_d  = tx_byte_q;
    tx_load_d  = 1'b0;
    cs_n_d     = cs_n_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    timeout_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cmd_start) begin
          frame_d    = {START_BITS, cmd_index, cmd_arg, crc_byte};
          byte_cnt_d = '0;
          cs_n_d     = 1'b0;
          busy_d     = 1'b1;
          state_d    = StSendLd;
        end
      end
      StSendLd: begin
        tx_byte_d = frame_q[FRAME_BITS-1 -: 8];
        tx_load_d = 1'b1;
        state_d   = StSendWt;
      end
      StSendWt: begin
        if (spi_byte_done) begin
          frame_d    = {frame_q[FRAME_BITS-9:0], 8'h00};
          byte_cnt_d = byte_cnt_q + 3'd1;
          if (byte_cnt_d == 3'(FRAME_BYTES)) begin
            poll_cnt_d = '0;
            state_d    = StPollLd;
          end else begin
            state_d = StSendLd;
          end
        end
      end
      StPollLd: begin
        tx_byte_d = FILL_BYTE;
        tx_load_d = 1'b1;
        state_d   = StPollWt;
      end
      StPollWt: begin
        if (spi_byte_done) begin
          if (!spi_rx_byte[7]) begin
            resp_d  = spi_rx_byte;
            flag_d  = 1'b0;
            state_d = StTrailLd;
          end else if (poll_cnt_q == PollW'(NCR_MAX - 1)) begin
            resp_d  = 8'hFF;
            flag_d  = 1'b1;
            state_d = StTrailLd;
          end else begin
            poll_cnt_d = poll_cnt_q + PollW'(1);
            state_d    = StPollLd;
          end
        end
      end
      StTrailLd: begin
        tx_byte_d = FILL_BYTE;
        tx_load_d = 1'b1;
        state_d   = StTrailWt;
      end
      StTrailWt: begin
        // Completion flags are set here so they are visible during the FINISH cycle
        if (spi_byte_done) begin
          done_d    = 1'b1;
          timeout_d = flag_q;
          cs_n_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = StFinish;
        end
      end
      StFinish: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      frame_q    <= '0;
      byte_cnt_q <= '0;
      poll_cnt_q <= '0;
      flag_q     <= 1'b0;
      resp_q     <= 8'hFF;
      tx_byte_q  <= 8'hFF;
      tx_load_q  <= 1'b0;
      cs_n_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      byte_cnt_q <= byte_cnt_d;
      poll_cnt_q <= poll_cnt_d;
      flag_q     <= flag_d;
      resp_q     <= resp_d;
      tx_byte_q  <= tx_byte_d;
      tx_load_q  <= tx_load_d;
      cs_n_q     <= cs_n_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
    end
  end

  assign cmd_busy    = busy_q;
  assign cmd_done    = done_q;
  assign cmd_timeout = timeout_q;
  assign resp_r1     = resp_q;
  assign spi_tx_byte = tx_byte_q;
  assign spi_tx_load = tx_load_q;
  assign sd_cs_n     = cs_n_q;

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Self-checking bench for sd_cmd_sequencer: a behavioural SPI shifter/card model drives
// randomized command transactions; expected bytes and results come from a frame-level model.
module tb_sd_cmd_sequencer;

  localparam int unsigned NCR  = 8;
  localparam logic [7:0]  FILL = 8'hFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_start;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        cmd_busy;
  logic        cmd_done;
  logic        cmd_timeout;
  logic [7:0]  resp_r1;
  logic [7:0]  spi_tx_byte;
  logic        spi_tx_load;
  logic        spi_byte_done;
  logic [7:0]  spi_rx_byte;
  logic        sd_cs_n;

  int n_checks = 0;
  int n_errors = 0;

  sd_cmd_sequencer #(
    .NCR_MAX   (NCR),
    .FILL_BYTE (FILL)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_start     (cmd_start),
    .cmd_index     (cmd_index),
    .cmd_arg       (cmd_arg),
    .cmd_busy      (cmd_busy),
    .cmd_done      (cmd_done),
    .cmd_timeout   (cmd_timeout),
    .resp_r1       (resp_r1),
    .spi_tx_byte   (spi_tx_byte),
    .spi_tx_load   (spi_tx_load),
    .spi_byte_done (spi_byte_done),
    .spi_rx_byte   (spi_rx_byte),
    .sd_cs_n       (sd_cs_n)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected 48-bit command frame; CRC by long division of {head, 7'b0} by 0x89
  function automatic logic [47:0] ref_frame(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] head;
    logic [7:0]  last;
`ifdef SD_CMD_CRC7_EN
    logic [46:0] v;
`endif
    head = {2'b01, idx, arg};
`ifdef SD_CMD_CRC7_EN
    v = {head, 7'b0};
    for (int i = 46; i >= 7; i--) begin
      if (v[i]) v = v ^ (47'h89 << (i - 7));
    end
    last = {v[6:0], 1'b1};
`else
    if (idx == 6'd0)      last = 8'h95;
    else if (idx == 6'd8) last = 8'h87;
    else                  last = 8'hFF;
`endif
    return {head, last};
  endfunction

  // One transaction; n_ff = FF bytes the card returns before r1. abort_at >= 0 resets the
  // DUT while that byte is outstanding.
  task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input int n_ff,
                         input logic [7:0] r1, input int abort_at);
    logic [47:0] fr;
    logic [7:0]  exp_b;
    logic [7:0]  exp_resp;
    int          polls;
    int          total;
    int          w;
    bit          tmo;
    fr       = ref_frame(idx, arg);
    tmo      = (n_ff >= int'(NCR));
    polls    = tmo ? int'(NCR) : n_ff + 1;
    total    = 6 + polls + 1;
    exp_resp = tmo ? 8'hFF : r1;

    cmd_index = idx;
    cmd_arg   = arg;
    cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    cmd_index = 6'($urandom);
    cmd_arg   = $urandom;
    check_val("busy_after_accept", 32'(cmd_busy), 1);
    check_val("cs_after_accept", 32'(sd_cs_n), 0);

    for (int b = 0; b < total; b++) begin
      w = 0;
      while (!spi_tx_load && w < 20) begin
        @(negedge clk);
        w++;
      end
      if (!spi_tx_load) begin
        check_val("load_wait", 0, 1);
        return;
      end
      exp_b = (b < 6) ? fr[47 - 8 * b -: 8] : FILL;
      check_val($sformatf("tx_byte[%0d]", b), 32'(spi_tx_byte), 32'(exp_b));
      check_val("cs_low", 32'(sd_cs_n), 0);

      if (b == abort_at) begin
        rst = 1'b1;
        #1;
        check_val("abort_cs", 32'(sd_cs_n), 1);
        check_val("abort_load", 32'(spi_tx_load), 0);
        check_val("abort_busy", 32'(cmd_busy), 0);
        check_val("abort_done", 32'(cmd_done), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        return;
      end

      // Shifter latency; stray cmd_start pulses while busy must be ignored
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        check_val("one_load_per_byte", 32'(spi_tx_load), 0);
        cmd_start = ($urandom_range(0, 2) == 0);
      end
      cmd_start = 1'b0;

      if (b >= 6 && b < 6 + polls) spi_rx_byte = ((b - 6) < n_ff) ? 8'hFF : r1;
      else                         spi_rx_byte = 8'($urandom);
      spi_byte_done = 1'b1;
      @(negedge clk);
      // Occasionally hold done through the following *_LD cycle, where it must be ignored
      if (b < total - 1 && $urandom_range(0, 3) == 0) @(negedge clk);
      spi_byte_done = 1'b0;
    end

    check_val("done_pulse", 32'(cmd_done), 1);
    check_val("timeout_flag", 32'(cmd_timeout), 32'(tmo));
    check_val("resp_r1", 32'(resp_r1), 32'(exp_resp));
    check_val("cs_release", 32'(sd_cs_n), 1);
    check_val("busy_release", 32'(cmd_busy), 0);
    check_val("no_load_finish", 32'(spi_tx_load), 0);
    @(negedge clk);
    check_val("done_one_cycle", 32'(cmd_done), 0);
    check_val("timeout_one_cycle", 32'(cmd_timeout), 0);
    check_val("resp_held", 32'(resp_r1), 32'(exp_resp));
  endtask

  logic [5:0] idx_tbl [6];

  initial begin
    idx_tbl       = '{6'd0, 6'd8, 6'd17, 6'd24, 6'd55, 6'd41};
    rst           = 1'b1;
    cmd_start     = 1'b0;
    cmd_index     = '0;
    cmd_arg       = '0;
    spi_byte_done = 1'b0;
    spi_rx_byte   = 8'hFF;
    repeat (3) @(negedge clk);
    check_val("rst_cs", 32'(sd_cs_n), 1);
    check_val("rst_busy", 32'(cmd_busy), 0);
    check_val("rst_done", 32'(cmd_done), 0);
    check_val("rst_timeout", 32'(cmd_timeout), 0);
    check_val("rst_load", 32'(spi_tx_load), 0);
    check_val("rst_tx_byte", 32'(spi_tx_byte), 32'hFF);
    check_val("rst_resp", 32'(resp_r1), 32'hFF);
    rst = 1'b0;
    @(negedge clk);

    // Directed: CMD0 (one FF poll then 01), CMD8, CMD17, NCR timeout
    run_cmd(6'd0, 32'h0, 1, 8'h01, -1);
    run_cmd(6'd8, 32'h1AA, 0, 8'h01, -1);
    run_cmd(6'd17, 32'h0, 0, 8'h00, -1);
    run_cmd(6'd55, 32'h0, 20, 8'h00, -1);

    // Spurious byte-done in IDLE: no reaction, following frame intact
    spi_rx_byte   = 8'h00;
    spi_byte_done = 1'b1;
    @(negedge clk);
    spi_byte_done = 1'b0;
    check_val("idle_spurious_load", 32'(spi_tx_load), 0);
    check_val("idle_spurious_busy", 32'(cmd_busy), 0);
    check_val("idle_spurious_cs", 32'(sd_cs_n), 1);
    @(negedge clk);
    check_val("idle_spurious_load2", 32'(spi_tx_load), 0);
    run_cmd(6'd24, 32'hDEAD_BEEF, 2, 8'h05, -1);

    // Reset with the fourth frame byte outstanding, then a full CMD0
    run_cmd(6'd41, 32'h4000_0000, 0, 8'h00, 3);
    run_cmd(6'd0, 32'h0, 0, 8'h01, -1);

    // Randomized transactions, including NCR boundary (n_ff = NCR-1 vs NCR)
    for (int t = 0; t < 40; t++) begin
      logic [5:0] idx;
      idx = ($urandom_range(0, 1) == 0) ? idx_tbl[$urandom_range(0, 5)] : 6'($urandom);
      run_cmd(idx, $urandom, $urandom_range(0, 10), 8'($urandom) & 8'h7F, -1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sd_cmd_sequencer.md
Name: sd_cmd_sequencer

Overview:
Sequences one SPI-mode SD command transaction over the shared byte-level SPI shifter. It frames a 6-byte command (start bits, index, 32-bit argument, CRC7/stop), polls for the R1 response within an NCR window, then clocks one trailer byte. Finally it releases chip select and reports completion or timeout. It sits between the SD mode controller, which issues CMD0/8/17/24/55/41 requests, and the SPI byte shifter.

Parameters:
NCR_MAX, 8, maximum number of 0xFF poll bytes sent while waiting for R1 (minimum 1).
FILL_BYTE, 8'hFF, byte transmitted during polling and trailer.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
cmd_start  input  1  single-cycle request; sampled only in IDLE
cmd_index  input  6  command index, latched on accepted cmd_start
cmd_arg  input  32  command argument, latched on accepted cmd_start
cmd_busy  output  1  high from the cycle after acceptance until cmd_done
cmd_done  output  1  one-cycle pulse at end of transaction
cmd_timeout  output  1  one-cycle pulse coincident with cmd_done when no R1 was seen
resp_r1  output  8  captured R1; valid from cmd_done until the next accept
spi_tx_byte  output  8  byte presented to the shifter
spi_tx_load  output  1  one-cycle pulse; shifter starts transferring spi_tx_byte
spi_byte_done  input  1  one-cycle pulse; shifter finished a byte and spi_rx_byte is valid
spi_rx_byte  input  8  byte received during the last transfer
sd_cs_n  output  1  SD chip select, active low

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (rst). All outputs are registered.
- Reset values:
  - State IDLE; sd_cs_n=1; cmd_busy=0; cmd_done=0; cmd_timeout=0; spi_tx_load=0.
  - spi_tx_byte=8'hFF; resp_r1=8'hFF; byte and poll counters 0.
- Reset mid-operation returns immediately to IDLE with the reset values above. No partial frame is resumed.
- States: IDLE, SEND_LD, SEND_WT, POLL_LD, POLL_WT, TRAIL_LD, TRAIL_WT, FINISH.
- IDLE: on cmd_start, latch frame = {2'b01, cmd_index, cmd_arg, crc7, 1'b1} (48 bits). Clear byte_cnt, drive sd_cs_n=0, set cmd_busy=1, go to SEND_LD.
- SEND_LD: spi_tx_byte=frame[47:40], pulse spi_tx_load, go to SEND_WT.
- SEND_WT: on spi_byte_done, shift frame left by 8 and increment byte_cnt.
  - byte_cnt reaches 6: clear poll_cnt, go to POLL_LD.
  - Otherwise: go to SEND_LD.
- POLL_LD: spi_tx_byte=FILL_BYTE, pulse spi_tx_load, go to POLL_WT.
- POLL_WT: on spi_byte_done:
  - spi_rx_byte[7]==0: resp_r1<=spi_rx_byte, timeout flag=0, go to TRAIL_LD.
  - Otherwise, if poll_cnt==NCR_MAX-1: resp_r1<=8'hFF, timeout flag=1, go to TRAIL_LD.
  - Otherwise: increment poll_cnt, go to POLL_LD.
- TRAIL_LD / TRAIL_WT: send one FILL_BYTE with sd_cs_n still 0. When spi_byte_done arrives, go to FINISH.
- FINISH: single cycle with cmd_done=1 and cmd_timeout=flag. sd_cs_n and cmd_busy return to 1/0 in the same cycle. Next state IDLE.
- Latency: cmd_done is asserted exactly 1 cycle after the trailer spi_byte_done. A cmd_start arriving in the cycle after FINISH (IDLE) is accepted.
- cmd_start while not in IDLE is ignored (no queuing). spi_byte_done in any *_LD, IDLE or FINISH state is ignored.
- Exactly one spi_tx_load per byte. A load is never issued while a byte is outstanding.
- Counters: byte_cnt is 3 bits; poll_cnt is $clog2(NCR_MAX)+1 bits. Neither wraps in legal operation.

Optional Feature:
SD_CMD_CRC7_EN.
- Defined: the sd_crc7 instance computes the CRC7 (poly x^7+x^3+1, init 0) over the first 40 frame bits, combinationally at latch time.
- Undefined: no CRC logic. The last byte is 8'h95 for index 0, 8'h87 for index 8, and 8'hFF otherwise.
- All other behaviour is identical in both builds.

Decomposition:
- Package sd_cmd_pkg:
  - State enum.
  - Command index constants CMD0=0, CMD8=8, CMD17=17, CMD24=24, CMD55=55, ACMD41=41.
  - FRAME_BYTES=6, START_BITS=2'b01, fixed CRC bytes 8'h95 and 8'h87.
- Sub-module sd_crc7: purely combinational, 40-bit input, 7-bit output. Instantiated only under SD_CMD_CRC7_EN.

Test Plan:
- CMD0, arg 0; rx FF then 01 -> TX 40 00 00 00 00 95, then FF FF polls, then FF trailer. cmd_done with resp_r1=8'h01, cmd_timeout=0, 9 loads total.
- CMD8, arg 32'h1AA; rx 01 on first poll -> TX 48 00 00 01 AA 87. (CRC build) CMD17, arg 0 -> last byte 8'h55.
- NCR_MAX=8, rx always FF -> exactly 8 poll bytes plus 1 trailer. cmd_done and cmd_timeout pulse together; resp_r1=8'hFF; sd_cs_n=1 in the same cycle.
- cmd_start pulsed during SEND_WT with a different index -> ignored; the frame continues unchanged and a single cmd_done results.
- rst asserted mid SEND_WT (after byte 3) -> sd_cs_n=1, spi_tx_load=0, busy=0 immediately. A new CMD0 afterwards produces a full 6-byte frame.
- Spurious spi_byte_done in SEND_LD and in IDLE -> no state or counter change, no extra spi_tx_load.
